fxu_reservation_station: RTL
============================

// Module: fxu_reservation_station
// PURPOSE
//  Per-FXU reservation station, directly downstream of the instruction buffer's out_fxu_N_* dispatch ports.
//  Holds dispatched ops until both operands are valid, capturing missing operands from the result broadcast.
//  Issues one ready op per cycle to the FXU ALU through a registered valid/ready output stage.
//  Drives the fxu_N_full back-pressure that the instruction buffer uses to stall dispatch.
// PARAMETERS
//  DEPTH   4   entries; 2..16
//  DATA_W  16  operand/result width
//  TAG_W   4   ROB index/owner tag width
//  OP_W    4   opcode width
//  IMM_W   8   immediate width
// PORTS
//  clk           in   1       clock, all state on posedge
//  rst_n         in   1       asynchronous active-low reset
//  flush         in   1       sync squash of all held ops
//  in_valid      in   1       dispatch strobe (out_fxu_N_instr_valid)
//  in_rob_idx    in   TAG_W   ROB slot of dispatched op
//  in_opcode     in   OP_W    opcode
//  in_imm        in   IMM_W   immediate
//  in_a_valid    in   1       operand A value present
//  in_a_value    in   DATA_W  operand A value
//  in_a_owner    in   TAG_W   ROB tag producing A when !in_a_valid
//  in_b_valid/in_b_value/in_b_owner  in  1/DATA_W/TAG_W  as for A
//  full          out  1       no free entry this cycle
//  cdb_valid     in   1       result broadcast strobe
//  cdb_tag       in   TAG_W   ROB tag of broadcast result
//  cdb_value     in   DATA_W  broadcast result
//  iss_valid     out  1       issue register holds an op
//  iss_ready     in   1       ALU accepts op this cycle
//  iss_rob_idx/iss_opcode/iss_imm/iss_a/iss_b  out  TAG_W/OP_W/IMM_W/DATA_W/DATA_W  issued op
// BEHAVIOUR
//  Reset: all entries invalid, iss_valid=0, all iss_* payload=0, full=0.
//  full = &entry_valid, combinational from entry state only. It does not look ahead to same-cycle frees.
//  Dispatch: in_valid && !full && !flush writes the lowest-index free entry.
//  Dispatch when full is a protocol error: the op is dropped and an assertion fires.
//  Dispatch bypass: if cdb_valid && cdb_tag==in_X_owner && !in_X_valid, operand X is stored valid with cdb_value.
//  Wakeup: every held entry with !X_valid && X_owner==cdb_tag && cdb_valid sets X_valid and X_value=cdb_value.
//  Operands A and B wake independently. Both may wake from the same broadcast.
//  Ready: entry_valid && a_valid && b_valid, evaluated on registered entry state.
//  Consequence: a woken operand makes its entry eligible one cycle later; no CDB-to-issue bypass.
//  Select: lowest-index ready entry. The issue register loads when (!iss_valid || iss_ready) && any_ready && !flush.
//  The chosen entry is freed in the same edge it is loaded.
//  Latency: op dispatched with both operands valid at edge N is selectable after N; iss_valid rises at edge N+1.
//  Handshake: iss_* payload stays stable while iss_valid && !iss_ready.
//  Transfer happens on iss_valid && iss_ready. Back-to-back issue is allowed with iss_ready held high.
//  iss_valid falls after a transfer when no entry is ready.
//  A freed entry may be re-dispatched in the following cycle. full reflects the free on the next cycle.
//  Flush: at the edge, all entries are invalidated and iss_valid clears. Any dispatch or CDB capture that cycle is discarded.
//  Flush has priority over every other event.
//  Reset mid-operation: immediately returns all state to the reset values, with no drain.
//  Tags are compared at full TAG_W width. ROB wrap-around is the ROB's concern; live tags are unique.
//  Simultaneous dispatch, wakeup and issue in one cycle are all legal and independent.
// STRUCTURE
//  Shared package ooo_pkg: DATA_W/TAG_W/OP_W/IMM_W localparams.
//  ooo_pkg also holds the opcode enum (MOV_IMM=5/6 etc.) and the rs_entry_t struct {valid,rob_idx,opcode,imm,a/b valid,value,owner}.
//  Sub-module rs_entry: one entry's storage plus its dispatch-bypass and wakeup compare logic.
//  The top level holds the free/ready priority encoders, the issue register and the flush handling.
// TESTING
//  1. Reset, then dispatch rob 3, opcode 0, A=5 valid, B=7 valid, iss_ready=1 -> iss_valid at edge N+1 with iss_a=5, iss_b=7, iss_rob_idx=3.
//  2. Dispatch rob 2 with A waiting on tag 9; 3 cycles later cdb_tag=9, value 0x1234 -> iss_valid exactly 1 cycle after the CDB, iss_a=0x1234.
//  3. Dispatch with A owner 4 in the same cycle as cdb_valid, tag 4, value 0xBEEF -> captured. Issues after 1 cycle, iss_a=0xBEEF.
//  4. Four ops waiting on tag 1, iss_ready=0 -> full=1 after the 4th. CDB tag 1 wakes all four.
//     Hold iss_ready=0 for 5 cycles -> payload unchanged, lowest entry shown.
//     Release iss_ready -> entries issue in index order 0..3, one per cycle.
//  5. Entries 0 and 2 ready, iss_valid held, flush=1 plus same-cycle dispatch -> next cycle iss_valid=0, full=0, no entry valid, and the dispatch is dropped.
//  6. rst_n low mid-stream with 3 entries held and iss_valid=1 -> outputs reach reset values asynchronously. No issue after rst_n rises.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: datapath widths, opcodes, reservation-station entry layout
// and the operand-capture compare used at dispatch and at wakeup.
package ooo_pkg;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 4;
  localparam int IMM_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_XOR     = 4'd4,
    OP_MOV_IMM = 4'd5,
    OP_ADD_IMM = 4'd6,
    OP_SHL     = 4'd7,
    OP_SHR     = 4'd8
  } opcode_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_idx;
    logic [OP_W-1:0]   opcode;
    logic [IMM_W-1:0]  imm;
    logic              a_valid;
    logic [DATA_W-1:0] a_value;
    logic [TAG_W-1:0]  a_owner;
    logic              b_valid;
    logic [DATA_W-1:0] b_value;
    logic [TAG_W-1:0]  b_owner;
  } rs_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  rob_idx;
    logic [OP_W-1:0]   opcode;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } issue_t;

  // A missing operand is captured when the broadcast carries its producer's tag.
  function automatic logic cdb_hit(input logic             have,
                                   input logic [TAG_W-1:0] owner,
                                   input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_tag);
    return !have && cdb_valid && (owner == cdb_tag);
  endfunction

endpackage

// File: rtl/fxu_reservation_station_if.sv
// Dispatch, result-broadcast and issue signals between the instruction buffer/CDB/ALU
// (master side) and the FXU reservation station (slave side).
interface fxu_reservation_station_if;
  import ooo_pkg::*;

  logic              flush;
  logic              in_valid;
  logic [TAG_W-1:0]  in_rob_idx;
  logic [OP_W-1:0]   in_opcode;
  logic [IMM_W-1:0]  in_imm;
  logic              in_a_valid;
  logic [DATA_W-1:0] in_a_value;
  logic [TAG_W-1:0]  in_a_owner;
  logic              in_b_valid;
  logic [DATA_W-1:0] in_b_value;
  logic [TAG_W-1:0]  in_b_owner;
  logic              full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              iss_valid;
  logic              iss_ready;
  logic [TAG_W-1:0]  iss_rob_idx;
  logic [OP_W-1:0]   iss_opcode;
  logic [IMM_W-1:0]  iss_imm;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;

  modport master (
    output flush, in_valid, in_rob_idx, in_opcode, in_imm,
           in_a_valid, in_a_value, in_a_owner, in_b_valid, in_b_value, in_b_owner,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    input  full, iss_valid, iss_rob_idx, iss_opcode, iss_imm, iss_a, iss_b
  );

  modport slave (
    input  flush, in_valid, in_rob_idx, in_opcode, in_imm,
           in_a_valid, in_a_value, in_a_owner, in_b_valid, in_b_value, in_b_owner,
           cdb_valid, cdb_tag, cdb_value, iss_ready,
    output full, iss_valid, iss_rob_idx, iss_opcode, iss_imm, iss_a, iss_b
  );

endinterface

// File: rtl/rs_entry.sv
// One reservation-station slot: holds a dispatched op and captures missing operands
// from the result broadcast, both on the dispatch cycle and while waiting.
module rs_entry
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              free,
  input  rs_entry_t         din,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              valid,
  output logic              ready,
  output issue_t            payload
);

  rs_entry_t q;
  logic      a_bypass, b_bypass, a_wake, b_wake;

  assign a_bypass = cdb_hit(din.a_valid, din.a_owner, cdb_valid, cdb_tag);
  assign b_bypass = cdb_hit(din.b_valid, din.b_owner, cdb_valid, cdb_tag);
  assign a_wake   = q.valid && cdb_hit(q.a_valid, q.a_owner, cdb_valid, cdb_tag);
  assign b_wake   = q.valid && cdb_hit(q.b_valid, q.b_owner, cdb_valid, cdb_tag);

  // load and free never coincide: only free slots are loaded, only valid ones are freed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (load) begin
      q <= din;
      if (a_bypass) begin
        q.a_valid <= 1'b1;
        q.a_value <= cdb_value;
      end
      if (b_bypass) begin
        q.b_valid <= 1'b1;
        q.b_value <= cdb_value;
      end
    end else begin
      if (free) q.valid <= 1'b0;
      if (a_wake) begin
        q.a_valid <= 1'b1;
        q.a_value <= cdb_value;
      end
      if (b_wake) begin
        q.b_valid <= 1'b1;
        q.b_value <= cdb_value;
      end
    end
  end

  assign valid   = q.valid;
  assign ready   = q.valid && q.a_valid && q.b_valid;
  assign payload = '{rob_idx: q.rob_idx, opcode: q.opcode, imm: q.imm,
                     a: q.a_value, b: q.b_value};

endmodule

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: lowest-free dispatch, lowest-ready select and a registered
// valid/ready issue stage feeding the ALU; full back-pressures the instruction buffer.
module fxu_reservation_station
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fxu_reservation_station_if.slave rs
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        din;
  logic [DEPTH-1:0] entry_valid, entry_ready, load_oh, free_oh;
  issue_t           entry_payload [DEPTH];
  logic [IDX_W-1:0] sel_idx;
  logic             any_ready, dispatch_we, iss_load, iss_valid_q;
  issue_t           iss_q;

  always_comb begin
    din         = '0;
    din.valid   = rs.in_valid;
    din.rob_idx = rs.in_rob_idx;
    din.opcode  = rs.in_opcode;
    din.imm     = rs.in_imm;
    din.a_valid = rs.in_a_valid;
    din.a_value = rs.in_a_value;
    din.a_owner = rs.in_a_owner;
    din.b_valid = rs.in_b_valid;
    din.b_value = rs.in_b_value;
    din.b_owner = rs.in_b_owner;
  end

  assign rs.full     = &entry_valid;
  assign dispatch_we = rs.in_valid && !rs.full && !rs.flush;
  assign any_ready   = |entry_ready;
  assign iss_load    = (!iss_valid_q || rs.iss_ready) && any_ready && !rs.flush;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    load_oh = '0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_valid[i]) begin
        load_oh    = '0;
        load_oh[i] = dispatch_we;
      end
      if (entry_ready[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) free_oh[i] = iss_load && (sel_idx == IDX_W'(i));
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rs_entry u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (rs.flush),
      .load      (load_oh[g]),
      .free      (free_oh[g]),
      .din       (din),
      .cdb_valid (rs.cdb_valid),
      .cdb_tag   (rs.cdb_tag),
      .cdb_value (rs.cdb_value),
      .valid     (entry_valid[g]),
      .ready     (entry_ready[g]),
      .payload   (entry_payload[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else if (rs.flush) begin
      iss_valid_q <= 1'b0;
    end else if (iss_load) begin
      iss_valid_q <= 1'b1;
      iss_q       <= entry_payload[sel_idx];
    end else if (rs.iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign rs.iss_valid   = iss_valid_q;
  assign rs.iss_rob_idx = iss_q.rob_idx;
  assign rs.iss_opcode  = iss_q.opcode;
  assign rs.iss_imm     = iss_q.imm;
  assign rs.iss_a       = iss_q.a;
  assign rs.iss_b       = iss_q.b;

  // The instruction buffer must stall on full; an op offered anyway is dropped.
  dispatch_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(rs.in_valid && rs.full && !rs.flush));

endmodule
